// File: rtl/pm_loader_if.sv
// Program-memory loader bus: load command, byte stream, memory write port and status.
// The slave modport is the loader side; the master modport is the host/test side.
interface pm_loader_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADD_WIDTH  = 7,
  parameter int WIDTH      = 8
);
  logic                  load_start;
  logic [ADD_WIDTH:0]    load_len;
  logic [WIDTH-1:0]      byte_in;
  logic                  byte_valid;
  logic                  byte_ready;
  logic                  pm_wr_en;
  logic [ADD_WIDTH-1:0]  pm_addr;
  logic [DATA_WIDTH-1:0] pm_data;
  logic                  busy;
  logic                  done;
  logic                  cpu_run;
  logic                  err;

  modport master (
    output load_start, load_len, byte_in, byte_valid,
    input  byte_ready, pm_wr_en, pm_addr, pm_data, busy, done, cpu_run, err
  );

  modport slave (
    input  load_start, load_len, byte_in, byte_valid,
    output byte_ready, pm_wr_en, pm_addr, pm_data, busy, done, cpu_run, err
  );
endinterface

// File: rtl/pm_loader.sv
// Byte-stream program-memory loader: packs bytes little-endian into words and writes them out.
// Optional trailing XOR checksum byte is enabled by defining PM_LOADER_CHECKSUM_EN.
module pm_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADD_WIDTH  = 7,
  parameter int WIDTH      = 8
) (
  input logic        clk,
  input logic        rst_n,
  pm_loader_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_WRITE,
`ifdef PM_LOADER_CHECKSUM_EN
    ST_CHK,
`endif
    ST_DONE
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [ADD_WIDTH:0]    len_q;
  logic [ADD_WIDTH-1:0]  addr_q;
  logic [1:0]            byte_idx;
  logic [DATA_WIDTH-1:0] data_q;
  logic [ADD_WIDTH:0]    words_done;
  logic                  byte_ready_c;
  logic                  wr_en_c;
  logic                  busy_c;
  logic                  accept;
  logic                  start_load;
  logic                  err_w;

  assign words_done = {1'b0, addr_q} + (ADD_WIDTH+1)'(1);
  assign accept     = bus.byte_valid && byte_ready_c;
  assign start_load = bus.load_start && (bus.load_len != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // byte_valid is only consulted in states where byte_ready is high, so it doubles as accept
  always_comb begin
    state_nxt    = state;
    byte_ready_c = 1'b0;
    wr_en_c      = 1'b0;
    busy_c       = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (bus.load_start)
          state_nxt = (bus.load_len == '0) ? ST_DONE : ST_COLLECT;
      end
      ST_COLLECT: begin
        byte_ready_c = 1'b1;
        busy_c       = 1'b1;
        if (bus.byte_valid && (byte_idx == 2'd3))
          state_nxt = ST_WRITE;
      end
      ST_WRITE: begin
        wr_en_c = 1'b1;
        busy_c  = 1'b1;
        if (words_done < len_q)
          state_nxt = ST_COLLECT;
        else
`ifdef PM_LOADER_CHECKSUM_EN
          state_nxt = ST_CHK;
`else
          state_nxt = ST_DONE;
`endif
      end
`ifdef PM_LOADER_CHECKSUM_EN
      ST_CHK: begin
        byte_ready_c = 1'b1;
        busy_c       = 1'b1;
        if (bus.byte_valid)
          state_nxt = ST_DONE;
      end
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Bytes shift in from the top so the first one ends up in the least significant lane
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len_q    <= '0;
      addr_q   <= '0;
      byte_idx <= '0;
      data_q   <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start_load) begin
            len_q    <= bus.load_len;
            addr_q   <= '0;
            byte_idx <= '0;
            data_q   <= '0;
          end
        end
        ST_COLLECT: begin
          if (accept) begin
            data_q   <= {bus.byte_in, data_q[DATA_WIDTH-1:WIDTH]};
            byte_idx <= byte_idx + 2'd1;
          end
        end
        ST_WRITE: addr_q <= addr_q + ADD_WIDTH'(1);
        default: ;
      endcase
    end
  end

`ifdef PM_LOADER_CHECKSUM_EN
  logic [WIDTH-1:0] csum_q;
  logic             err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      csum_q <= '0;
      err_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start_load) begin
            csum_q <= '0;
            err_q  <= 1'b0;
          end
        end
        ST_COLLECT: if (accept) csum_q <= csum_q ^ bus.byte_in;
        ST_CHK:     if (accept) err_q  <= (bus.byte_in != csum_q);
        default: ;
      endcase
    end
  end

  assign err_w = err_q;
`else
  assign err_w = 1'b0;
`endif

  assign bus.byte_ready = byte_ready_c;
  assign bus.pm_wr_en   = wr_en_c;
  assign bus.pm_addr    = addr_q;
  assign bus.pm_data    = data_q;
  assign bus.busy       = busy_c;
  assign bus.done       = (state == ST_DONE);
  assign bus.cpu_run    = (state == ST_DONE) && !err_w;
  assign bus.err        = err_w;

endmodule

// File: tb/tb_pm_loader.sv
// Randomized self-checking bench for pm_loader; expected writes come from a byte-list model.
module tb_pm_loader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  pm_loader_if #(.DATA_WIDTH(32), .ADD_WIDTH(7), .WIDTH(8)) bus();

  pm_loader #(.DATA_WIDTH(32), .ADD_WIDTH(7), .WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int          assert_cnt = 0;
  int          fail_cnt   = 0;
  int          wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [7:0]  stim_bytes[$];
  logic        exp_err = 1'b0;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    assert_cnt++;
    if (observed !== expected) begin
      fail_cnt++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Every write strobe is logged; the loader must not be accepting bytes while writing
  always @(negedge clk) begin
    if (bus.pm_wr_en === 1'b1) begin
      wr_addr_q.push_back(int'(bus.pm_addr));
      wr_data_q.push_back(bus.pm_data);
      check_output("ready_in_write", 32'(bus.byte_ready), 32'd0);
      check_output("busy_in_write", 32'(bus.busy), 32'd1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_output({pfx, "_byte_ready"}, 32'(bus.byte_ready), 32'd0);
    check_output({pfx, "_pm_wr_en"},   32'(bus.pm_wr_en),   32'd0);
    check_output({pfx, "_pm_addr"},    32'(bus.pm_addr),    32'd0);
    check_output({pfx, "_pm_data"},    bus.pm_data,         32'd0);
    check_output({pfx, "_busy"},       32'(bus.busy),       32'd0);
    check_output({pfx, "_done"},       32'(bus.done),       32'd0);
    check_output({pfx, "_cpu_run"},    32'(bus.cpu_run),    32'd0);
    check_output({pfx, "_err"},        32'(bus.err),        32'd0);
  endtask

  task automatic fill_random(input int len);
    stim_bytes.delete();
    for (int i = 0; i < 4 * len; i++) stim_bytes.push_back(8'($urandom_range(0, 255)));
  endtask

  // mode: 0 = always valid, 1 = valid every other cycle, 2 = random valid
  task automatic apply_stimulus(input int len, input int mode, input bit poke, input bit bad);
    logic [7:0] seq[$];
    logic [7:0] csum;
    int         idx;
    int         cyc;
    int         limit;
    int         w;
    logic       v;
    logic       rdy;

    wr_addr_q.delete();
    wr_data_q.delete();
    seq = stim_bytes;
    csum = 8'h00;
    foreach (stim_bytes[i]) csum = csum ^ stim_bytes[i];
`ifdef PM_LOADER_CHECKSUM_EN
    if (len > 0) begin
      seq.push_back(bad ? csum + 8'd1 : csum);
      exp_err = bad;
    end
`else
    exp_err = 1'b0;
`endif

    bus.load_len   = 8'(len);
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;

    if (len == 0) begin
      check_output("len0_done", 32'(bus.done), 32'd1);
      check_output("len0_busy", 32'(bus.busy), 32'd0);
      check_output("len0_cpu_run", 32'(bus.cpu_run), 32'(!exp_err));
      tick();
      tick();
      check_output("len0_writes", 32'(wr_addr_q.size()), 32'd0);
      return;
    end

    idx   = 0;
    cyc   = 0;
    limit = seq.size() * 8 + 50;
    while (idx < seq.size() && cyc < limit) begin
      bus.byte_in    = seq[idx];
      bus.byte_valid = (mode == 0) ? 1'b1 :
                       (mode == 1) ? ((cyc % 2) == 1) :
                       ($urandom_range(0, 2) != 0);
      if (poke && cyc == 5) begin
        bus.load_start = 1'b1;
        bus.load_len   = 8'd3;
      end else begin
        bus.load_start = 1'b0;
      end
      v   = bus.byte_valid;
      rdy = bus.byte_ready;
      tick();
      if (v && rdy) idx++;
      cyc++;
    end
    bus.byte_valid = 1'b0;
    bus.load_start = 1'b0;
    check_output("bytes_accepted", 32'(idx), 32'(seq.size()));

    w = 0;
    while (bus.done !== 1'b1 && w < 20) begin
      tick();
      w++;
    end
    check_output("done", 32'(bus.done), 32'd1);
    check_output("busy_after", 32'(bus.busy), 32'd0);
    check_output("err", 32'(bus.err), 32'(exp_err));
    check_output("cpu_run", 32'(bus.cpu_run), 32'(!exp_err));
    check_output("write_count", 32'(wr_addr_q.size()), 32'(len));
    for (int i = 0; i < len && i < wr_addr_q.size(); i++) begin
      check_output("write_addr", 32'(wr_addr_q[i]), 32'(i));
      check_output("write_data", wr_data_q[i],
                   {stim_bytes[4*i+3], stim_bytes[4*i+2], stim_bytes[4*i+1], stim_bytes[4*i]});
    end
  endtask

  initial begin
    bus.load_start = 1'b0;
    bus.load_len   = '0;
    bus.byte_in    = '0;
    bus.byte_valid = 1'b0;

    rst_n = 1'b0;
    tick();
    tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // Known single-word program
    stim_bytes = '{8'h13, 8'h00, 8'h50, 8'h00};
    apply_stimulus(1, 0, 1'b0, 1'b0);
    if (wr_data_q.size() > 0) check_output("word0_literal", wr_data_q[0], 32'h00500013);
`ifdef PM_LOADER_CHECKSUM_EN
    apply_stimulus(1, 0, 1'b0, 1'b1);
    apply_stimulus(1, 0, 1'b0, 1'b0);
`endif

    // Two words with a source that stalls every other cycle
    fill_random(2);
    apply_stimulus(2, 1, 1'b0, 1'b0);

    // Reset after half a word: nothing may be written
    wr_addr_q.delete();
    bus.load_len   = 8'd1;
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    bus.byte_valid = 1'b1;
    bus.byte_in    = 8'hAA;
    tick();
    bus.byte_in    = 8'hBB;
    tick();
    bus.byte_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    check_reset_outputs("midload_reset");
    rst_n = 1'b1;
    tick();
    tick();
    check_output("midload_no_write", 32'(wr_addr_q.size()), 32'd0);
    fill_random(1);
    apply_stimulus(1, 2, 1'b0, 1'b0);

    // Empty load, then a load_start issued while busy
    stim_bytes.delete();
    apply_stimulus(0, 0, 1'b0, 1'b0);
    fill_random(4);
    apply_stimulus(4, 2, 1'b1, 1'b0);

    // Full memory
    fill_random(128);
    apply_stimulus(128, 2, 1'b0, 1'b0);
    if (wr_addr_q.size() > 0) check_output("last_addr", 32'(wr_addr_q[$]), 32'h7F);

    for (int n = 0; n < 6; n++) begin
      int len;
      len = $urandom_range(1, 16);
      fill_random(len);
      apply_stimulus(len, $urandom_range(0, 2), (len >= 2) && ($urandom_range(0, 1) == 1),
                     1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/pm_loader.md
PM_LOADER -- requirements
Module: pm_loader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: program-memory word width, fixed at 4 bytes.
REQ-002 SHALL have parameter ADD_WIDTH, default 7: program-memory address width.
REQ-003 SHALL have parameter WIDTH, default 8: byte-stream width.
REQ-004 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-006 SHALL have port load_start  input  1  one-cycle request to begin a load.
REQ-007 SHALL have port load_len  input  ADD_WIDTH+1  number of words to load (0..128), sampled with load_start.
REQ-008 SHALL have port byte_in  input  WIDTH  incoming program byte.
REQ-009 SHALL have port byte_valid  input  1  byte_in is valid.
REQ-010 SHALL have port byte_ready  output  1  loader accepts byte_in this cycle.
REQ-011 SHALL have port pm_wr_en  output  1  program-memory write strobe.
REQ-012 SHALL have port pm_addr  output  ADD_WIDTH  program-memory write address.
REQ-013 SHALL have port pm_data  output  DATA_WIDTH  program-memory write data.
REQ-014 SHALL have port busy  output  1  load in progress.
REQ-015 SHALL have port done  output  1  last load completed.
REQ-016 SHALL have port cpu_run  output  1  CPU release; 0 holds the CPU in reset.
REQ-017 SHALL have port err  output  1  checksum mismatch on last load.

Function
REQ-018 SHALL implement states IDLE, COLLECT, WRITE, CHK, DONE.
REQ-019 SHALL, in IDLE or DONE, on load_start with load_len=0, go to DONE with no pm write; with load_len>0, latch load_len, clear pm_addr, byte index, done, err and checksum, and go to COLLECT.
REQ-020 SHALL ignore load_start in COLLECT, WRITE and CHK.
REQ-021 SHALL drive byte_ready=1 only in COLLECT and CHK; a byte is accepted when byte_valid and byte_ready are both 1.
REQ-022 SHALL pack accepted bytes little-endian: 1st byte into pm_data[7:0], 4th into pm_data[31:24].
REQ-023 SHALL enter WRITE the cycle after the 4th byte is accepted, and assert pm_wr_en for exactly one cycle with pm_addr and pm_data stable.
REQ-024 SHALL, on leaving WRITE, increment pm_addr; go to COLLECT if words written < load_len, else to CHK (macro defined) or DONE (macro undefined).
REQ-025 SHALL never write pm_addr beyond load_len-1; load_len=128 writes 0..127 with no wrap.
REQ-026 SHALL drive busy=1 in COLLECT, WRITE and CHK only.
REQ-027 SHALL hold done=1 in DONE until the next accepted load_start.
REQ-028 SHALL drive cpu_run=1 only in DONE with err=0.
REQ-029 SHALL keep byte_valid without byte_ready from changing state; stalled byte sources are allowed indefinitely.

Reset
REQ-030 SHALL, when rst_n=0 at a clock edge, go to IDLE, including mid-load, with byte_ready=0, pm_wr_en=0, pm_addr=0, pm_data=0, busy=0, done=0, cpu_run=0, err=0.
REQ-031 SHALL discard any partially collected word on reset; no pm write follows.

Configuration
REQ-032 SHALL, with PM_LOADER_CHECKSUM_EN defined, keep a running XOR of all data bytes, accept one checksum byte in CHK, set err=1 on mismatch, then go to DONE.
REQ-033 SHALL, without PM_LOADER_CHECKSUM_EN, omit the CHK state and checksum logic and tie err to 0.

Verification
REQ-034 SHALL check: reset, load_start with load_len=1, bytes 0x13,0x00,0x50,0x00 -> one pm_wr_en pulse, pm_addr=0, pm_data=0x00500013, then done=1, cpu_run=1.
REQ-035 SHALL check: load_len=2 with byte_valid toggling every other cycle -> writes at addr 0 and 1 only, byte_ready=0 during each WRITE cycle.
REQ-036 SHALL check: rst_n=0 after 2 of 4 bytes -> no pm_wr_en, all outputs at reset values; a following load writes from addr 0.
REQ-037 SHALL check: load_start while busy -> ignored; load_len=0 -> done=1 next cycle, no pm_wr_en.
REQ-038 SHALL check: macro defined, data 0x13,0x00,0x50,0x00 with checksum 0x43 -> err=0, cpu_run=1; checksum 0x44 -> err=1, cpu_run=0.
REQ-039 SHALL check: load_len=128 -> 128 writes, last pm_addr=0x7F, no write to address 0 after the first.
